// File: rtl/reg_write_scoreboard_if.sv
// Issue / writeback / fetch-query bundle of the register write scoreboard.
// The pipeline side drives through master; the scoreboard receives through slave.
interface reg_write_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_is_load;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] fetch_instr;
  logic [4:0]  fetch_rs1;
  logic [4:0]  fetch_rs2;
  logic        stall;
  logic        load_stall;
  logic        sb_error;

  modport master (
    output issue_valid, issue_rd, issue_is_load, wb_valid, wb_rd, flush,
           fetch_instr, fetch_rs1, fetch_rs2,
    input  issue_ready, stall, load_stall, sb_error
  );

  modport slave (
    input  issue_valid, issue_rd, issue_is_load, wb_valid, wb_rd, flush,
           fetch_instr, fetch_rs1, fetch_rs2,
    output issue_ready, stall, load_stall, sb_error
  );
endinterface

// File: rtl/reg_write_scoreboard.sv
// Per-register pending-write tracker answering the fetch-stage RAW hazard query
// (branch/JALR stall, load-use stall) from registered state only.
module reg_write_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reg_write_scoreboard_if.slave bus
);

  localparam logic [6:0]       OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]       OPC_STORE  = 7'b0100011;
  localparam logic [6:0]       OPC_OP     = 7'b0110011;
  localparam logic [6:0]       OPC_LUI    = 7'b0110111;
  localparam logic [6:0]       OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]       OPC_JAL    = 7'b1101111;
  localparam logic [6:0]       OPC_JALR   = 7'b1100111;
  localparam logic [6:0]       OPC_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_INFLIGHT);

  // Entry 0 exists only so indexing by a raw register number is uniform; it stays zero.
  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            ld_q, ld_d;
  logic                   err_q, err_d;

  logic       issue_ready_s;
  logic       issue_acc_s;
  logic       wb_hit_s;
  logic [6:0] opcode_s;
  logic       is_br_s, is_jalr_s, rd_rs1_s, rd_rs2_s;
  logic       busy1_s, busy2_s;
  logic       unused_instr_s;

  // Saturation check; a same-cycle writeback to the register frees one slot.
  always_comb begin
    issue_ready_s = (cnt_q[bus.issue_rd] != CNT_MAX) |
                    (bus.wb_valid & (bus.wb_rd == bus.issue_rd));
    issue_acc_s   = bus.issue_valid & issue_ready_s & (bus.issue_rd != 5'd0);
    wb_hit_s      = bus.wb_valid & (bus.wb_rd != 5'd0);
  end

  // Next-state for counters, youngest-writer-is-load flags and sticky error.
  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    err_d = err_q;
    if (bus.flush) begin
      cnt_d = '0;
      ld_d  = '0;
    end else if (issue_acc_s && wb_hit_s && (bus.issue_rd == bus.wb_rd)) begin
      ld_d[bus.issue_rd] = bus.issue_is_load;
    end else begin
      if (issue_acc_s) begin
        cnt_d[bus.issue_rd] = cnt_q[bus.issue_rd] + CNT_ONE;
        ld_d[bus.issue_rd]  = bus.issue_is_load;
      end else begin
        cnt_d[bus.issue_rd] = cnt_d[bus.issue_rd];
      end
      if (wb_hit_s) begin
        if (cnt_q[bus.wb_rd] != CNT_ZERO) begin
          cnt_d[bus.wb_rd] = cnt_q[bus.wb_rd] - CNT_ONE;
          if (cnt_q[bus.wb_rd] == CNT_ONE) begin
            ld_d[bus.wb_rd] = 1'b0;
          end else begin
            ld_d[bus.wb_rd] = ld_d[bus.wb_rd];
          end
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = err_d;
      end
    end
    cnt_d[0] = CNT_ZERO;
    ld_d[0]  = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
      err_q <= err_d;
    end
  end

  // Fetch query: decode which sources the instruction reads, then look up pending state.
  always_comb begin
    opcode_s       = bus.fetch_instr[6:0];
    unused_instr_s = ^bus.fetch_instr[31:7];
    is_br_s        = (opcode_s == OPC_BRANCH);
    is_jalr_s      = (opcode_s == OPC_JALR);
    rd_rs1_s       = !((opcode_s == OPC_LUI) | (opcode_s == OPC_AUIPC) | (opcode_s == OPC_JAL));
    rd_rs2_s       = is_br_s | (opcode_s == OPC_STORE) | (opcode_s == OPC_OP);
    busy1_s        = (bus.fetch_rs1 != 5'd0) & (cnt_q[bus.fetch_rs1] != CNT_ZERO);
    busy2_s        = (bus.fetch_rs2 != 5'd0) & (cnt_q[bus.fetch_rs2] != CNT_ZERO);
    if (opcode_s == OPC_LOAD) begin
      rd_rs2_s = 1'b0;
    end else begin
      rd_rs2_s = rd_rs2_s;
    end
  end

  assign bus.issue_ready = issue_ready_s;
  assign bus.stall       = (is_br_s & (busy1_s | busy2_s)) | (is_jalr_s & busy1_s);
  assign bus.load_stall  = (rd_rs1_s & busy1_s & ld_q[bus.fetch_rs1]) |
                           (rd_rs2_s & busy2_s & ld_q[bus.fetch_rs2]);
  assign bus.sb_error    = err_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed-vector bench for reg_write_scoreboard: one task per scenario, inline checks.
module tb_reg_write_scoreboard;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_write_scoreboard_if bus();

  reg_write_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_rd      = 5'd0;
    bus.issue_is_load = 1'b0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = 5'd0;
    bus.flush         = 1'b0;
  endtask

  task automatic set_fetch(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.fetch_instr = {7'd0, rs2, rs1, 3'd0, 5'd0, op};
    bus.fetch_rs1   = rs1;
    bus.fetch_rs2   = rs2;
  endtask

  task automatic issue(input logic [4:0] rd, input logic is_load);
    bus.issue_valid   = 1'b1;
    bus.issue_rd      = rd;
    bus.issue_is_load = is_load;
    tick();
    idle();
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_fetch(OP_BRANCH, 5'd0, 5'd0);
    #12;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL reset_load_stall got=%b exp=0", bus.load_stall); end
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got=%b exp=1", bus.issue_ready); end
    checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL reset_sb_error got=%b exp=0", bus.sb_error); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_branch_stall();
    issue(5'd5, 1'b0);
    set_fetch(OP_BRANCH, 5'd5, 5'd0);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL beq_busy_stall got=%b exp=1", bus.stall); end
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL beq_busy_load_stall got=%b exp=0", bus.load_stall); end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wb_no_bypass got=%b exp=1", bus.stall); end
    tick();
    idle();
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL wb_release got=%b exp=0", bus.stall); end
  endtask

  task automatic test_load_use();
    issue(5'd7, 1'b1);
    set_fetch(OP_OP, 5'd0, 5'd7);
    #1;
    checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL add_rs2_load got=%b exp=1", bus.load_stall); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL add_no_branch_stall got=%b exp=0", bus.stall); end
    issue(5'd7, 1'b0);
    #1;
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL youngest_not_load got=%b exp=0", bus.load_stall); end
    set_fetch(OP_BRANCH, 5'd0, 5'd7);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL cnt2_busy got=%b exp=1", bus.stall); end
    wb(5'd7);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL cnt1_busy got=%b exp=1", bus.stall); end
    wb(5'd7);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL cnt0_free got=%b exp=0", bus.stall); end
    issue(5'd8, 1'b1);
    set_fetch(OP_LUI, 5'd8, 5'd8);
    #1;
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL lui_no_read got=%b exp=0", bus.load_stall); end
    set_fetch(OP_STORE, 5'd0, 5'd8);
    #1;
    checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL store_rs2 got=%b exp=1", bus.load_stall); end
    set_fetch(OP_IMM, 5'd0, 5'd8);
    #1;
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL addi_no_rs2 got=%b exp=0", bus.load_stall); end
    set_fetch(OP_IMM, 5'd8, 5'd0);
    #1;
    checks++; if (bus.load_stall !== 1'b1) begin errors++; $display("FAIL addi_rs1 got=%b exp=1", bus.load_stall); end
    wb(5'd8);
    #1;
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL load_released got=%b exp=0", bus.load_stall); end
  endtask

  task automatic test_saturation();
    issue(5'd3, 1'b0);
    issue(5'd3, 1'b0);
    issue(5'd3, 1'b0);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sat_ready got=%b exp=0", bus.issue_ready); end
    bus.issue_rd = 5'd4;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL other_ready got=%b exp=1", bus.issue_ready); end
    bus.issue_rd = 5'd3;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL sat_wb_ready got=%b exp=1", bus.issue_ready); end
    tick();
    idle();
    bus.issue_rd = 5'd3;
    #1;
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL cnt_stays_3 got=%b exp=0", bus.issue_ready); end
    wb(5'd3);
    bus.issue_rd = 5'd3;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL cnt2_ready got=%b exp=1", bus.issue_ready); end
    wb(5'd3);
    wb(5'd3);
    set_fetch(OP_BRANCH, 5'd3, 5'd0);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sat_drained got=%b exp=0", bus.stall); end
    checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL sat_no_error got=%b exp=0", bus.sb_error); end
  endtask

  task automatic test_x0_and_error();
    bus.issue_rd = 5'd0;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", bus.issue_ready); end
    issue(5'd0, 1'b1);
    set_fetch(OP_JALR, 5'd0, 5'd0);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL jalr_x0 got=%b exp=0", bus.stall); end
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL jalr_x0_load got=%b exp=0", bus.load_stall); end
    wb(5'd9);
    #1;
    checks++; if (bus.sb_error !== 1'b1) begin errors++; $display("FAIL wb_empty_error got=%b exp=1", bus.sb_error); end
    issue(5'd9, 1'b0);
    wb(5'd9);
    tick();
    checks++; if (bus.sb_error !== 1'b1) begin errors++; $display("FAIL error_sticky got=%b exp=1", bus.sb_error); end
  endtask

  task automatic test_flush();
    issue(5'd4, 1'b0);
    issue(5'd6, 1'b1);
    set_fetch(OP_BRANCH, 5'd4, 5'd6);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL bne_pending got=%b exp=1", bus.stall); end
    bus.flush       = 1'b1;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd4;
    tick();
    idle();
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_bne got=%b exp=0", bus.stall); end
    set_fetch(OP_OP, 5'd4, 5'd6);
    #1;
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL flush_ld got=%b exp=0", bus.load_stall); end
  endtask

  task automatic test_async_reset();
    issue(5'd10, 1'b1);
    issue(5'd10, 1'b1);
    set_fetch(OP_BRANCH, 5'd10, 5'd0);
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.load_stall !== 1'b1) begin
      errors++; $display("FAIL pre_reset got=%b%b exp=11", bus.stall, bus.load_stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL async_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.load_stall !== 1'b0) begin errors++; $display("FAIL async_load_stall got=%b exp=0", bus.load_stall); end
    checks++; if (bus.sb_error !== 1'b0) begin errors++; $display("FAIL async_sb_error got=%b exp=0", bus.sb_error); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_reset_beq got=%b exp=0", bus.stall); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch_stall();
    test_load_use();
    test_saturation();
    test_x0_and_error();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
